// File: rtl/avalon_result_writer_if.sv
// Avalon-MM write channel used by the result writer.
// The master drives the write request; the slave answers with waitrequest.
interface avalon_result_writer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   address;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;

  modport master (
    output address,
    output write,
    output writedata,
    output byteenable,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  write,
    input  writedata,
    input  byteenable,
    output waitrequest
  );
endinterface

// File: rtl/avalon_result_writer.sv
// Avalon-MM write master that drains the compute engine's result vector.
// A start pulse snapshots all N_ROWS results, then one single-beat write per row
// goes to BASE_ADDR + row*ADDR_STRIDE, followed by a one-cycle done pulse.
// dbg_row is 4 bits wide, so N_ROWS is limited to 16.
module avalon_result_writer #(
  parameter int          N_ROWS      = 8,
  parameter int          RES_W       = 24,
  parameter int          DATA_W      = 64,
  parameter int          ADDR_W      = 32,
  parameter int unsigned BASE_ADDR   = 16,
  parameter int unsigned ADDR_STRIDE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_ROWS*RES_W-1:0] c_in,
  avalon_result_writer_if.master  avm,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              dbg_state,
  output logic [3:0]              dbg_row
);

  localparam int IDX_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       row_q;
  logic [3:0]       row_d;
  logic             load;
  logic [RES_W-1:0] res_buf [N_ROWS];

  // State, row index and result snapshot registers; the snapshot is taken only on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      for (int i = 0; i < N_ROWS; i++) begin
        res_buf[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      if (load) begin
        for (int i = 0; i < N_ROWS; i++) begin
          res_buf[i] <= c_in[i*RES_W +: RES_W];
        end
      end
    end
  end

  // Sequencing: start is honoured only in IDLE, a row advances only when its write is accepted
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          row_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!avm.waitrequest) begin
          if (row_q == 4'(N_ROWS - 1)) begin
            state_d = DONE;
          end else begin
            row_d = row_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        row_d   = '0;
      end
      default: begin
        state_d = IDLE;
        row_d   = '0;
      end
    endcase
  end

  // Bus outputs decode only from registered state, row and snapshot, so they hold steady during stalls
  always_comb begin
    avm.write      = 1'b0;
    avm.address    = '0;
    avm.writedata  = '0;
    avm.byteenable = '0;
    if (state_q == WRITE) begin
      avm.write      = 1'b1;
      avm.address    = ADDR_W'(BASE_ADDR) + ADDR_W'(row_q) * ADDR_W'(ADDR_STRIDE);
      avm.writedata  = DATA_W'(res_buf[row_q[IDX_W-1:0]]);
      avm.byteenable = '1;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;
  assign dbg_row   = row_q;

endmodule

// File: tb/tb_avalon_result_writer.sv
// Self-checking bench for avalon_result_writer.
// A queue-based model predicts the bus and status outputs every cycle; directed
// scenarios add hand-computed expectations on the accepted write log and timing.
`timescale 1ns/1ps
module tb_avalon_result_writer;

  localparam int N_ROWS = 8;
  localparam int RES_W  = 24;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int BASE   = 16;
  localparam int STRIDE = 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [N_ROWS*RES_W-1:0] c_in;
  logic                    busy;
  logic                    done;
  logic [1:0]              dbg_state;
  logic [3:0]              dbg_row;

  avalon_result_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm ();

  avalon_result_writer #(
    .N_ROWS(N_ROWS), .RES_W(RES_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .BASE_ADDR(BASE), .ADDR_STRIDE(STRIDE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .c_in(c_in), .avm(avm),
    .busy(busy), .done(done), .dbg_state(dbg_state), .dbg_row(dbg_row)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a run is a queue of pending (address, data) writes; the head
  // is what must be on the bus, it pops on acceptance, and an empty queue means done.
  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_new;
  bit   m_valid  = 1'b0;
  bit   m_active = 1'b0;
  bit   m_done   = 1'b0;

  // Model update on the same edge the DUT samples its inputs
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_active = 1'b0;
      m_done   = 1'b0;
      m_valid  = 1'b1;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      if (!avm.waitrequest) begin
        exp_q.delete(0);
        if (exp_q.size() == 0) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (start) begin
      for (int r = 0; r < N_ROWS; r++) begin
        e_new.addr = 64'(BASE + r * STRIDE);
        e_new.data = 64'(c_in[r*RES_W +: RES_W]);
        exp_q.push_back(e_new);
      end
      m_active = 1'b1;
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("avm_write", 64'(avm.write), 64'(m_active));
      checkOutput("avm_address", 64'(avm.address), m_active ? exp_q[0].addr : 64'd0);
      checkOutput("avm_writedata", avm.writedata, m_active ? exp_q[0].data : 64'd0);
      checkOutput("avm_byteenable", 64'(avm.byteenable), m_active ? 64'hFF : 64'd0);
      checkOutput("done", 64'(done), 64'(m_done));
      checkOutput("busy", 64'(busy), 64'(m_active || m_done));
      checkOutput("dbg_state", 64'(dbg_state), m_active ? 64'd1 : (m_done ? 64'd2 : 64'd0));
      checkOutput("dbg_row", 64'(dbg_row),
                  m_active ? 64'(N_ROWS - exp_q.size()) : (m_done ? 64'(N_ROWS - 1) : 64'd0));
    end
  end

  // Log of accepted writes plus done and stall statistics
  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_t;

  wr_t dut_log[$];
  wr_t w_new;
  int  cyc           = 0;
  int  done_count    = 0;
  int  done_cyc      = 0;
  int  addr18_cycles = 0;
  int  start_cyc     = 0;
  logic [RES_W-1:0] rows_ref [N_ROWS];

  always @(negedge clk) begin
    cyc++;
    if (avm.write === 1'b1 && avm.waitrequest === 1'b0) begin
      w_new.addr = avm.address;
      w_new.data = avm.writedata;
      w_new.be   = avm.byteenable;
      dut_log.push_back(w_new);
    end
    if (avm.write === 1'b1 && avm.address == 32'd18) addr18_cycles++;
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  // Drive one cycle of inputs; start is always a single-cycle pulse
  task automatic applyStimulus(input logic st, input logic wr, input logic rs);
    start           = st;
    avm.waitrequest = wr;
    rst             = rs;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic setRows(input logic [RES_W-1:0] base, input logic [RES_W-1:0] step);
    for (int i = 0; i < N_ROWS; i++) begin
      rows_ref[i]               = base + RES_W'(i) * step;
      c_in[i*RES_W +: RES_W]    = rows_ref[i];
    end
  endtask

  task automatic clearLog();
    dut_log.delete();
    done_count    = 0;
    addr18_cycles = 0;
  endtask

  task automatic pulseStart();
    applyStimulus(1'b1, 1'b0, 1'b0);
    start_cyc = cyc;
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget && done_count == 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (done_count == 0) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic checkLog(input string tag, input int latency);
    checkOutput({tag, "_write_count"}, 64'(dut_log.size()), 64'(N_ROWS));
    checkOutput({tag, "_done_count"}, 64'(done_count), 64'd1);
    checkOutput({tag, "_latency"}, 64'(done_cyc - start_cyc), 64'(latency));
    for (int i = 0; i < N_ROWS && i < dut_log.size(); i++) begin
      checkOutput({tag, "_addr"}, 64'(dut_log[i].addr), 64'(16 + i));
      checkOutput({tag, "_data"}, dut_log[i].data, 64'(rows_ref[i]));
      checkOutput({tag, "_be"}, 64'(dut_log[i].be), 64'hFF);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    start           = 1'b0;
    avm.waitrequest = 1'b0;
    c_in            = '0;

    // Reset state
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("reset_write", 64'(avm.write), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_address", 64'(avm.address), 64'd0);
    checkOutput("reset_writedata", avm.writedata, 64'd0);
    checkOutput("reset_byteenable", 64'(avm.byteenable), 64'd0);
    checkOutput("reset_state", 64'(dbg_state), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // No stalls: results 1..8
    $display("[TB] scenario: back-to-back writes");
    clearLog();
    setRows(24'd1, 24'd1);
    pulseStart();
    waitDone(40);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkLog("nostall", 9);

    // Stall on row 2 for three cycles
    $display("[TB] scenario: stall on row 2");
    clearLog();
    setRows(24'h000010, 24'h000010);
    pulseStart();
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitDone(40);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkLog("stall", 12);
    checkOutput("stall_hold_cycles", 64'(addr18_cycles), 64'd4);

    // c_in overwritten right after start
    $display("[TB] scenario: input change after start");
    clearLog();
    setRows(24'h100000, 24'h000011);
    pulseStart();
    for (int i = 0; i < N_ROWS; i++) c_in[i*RES_W +: RES_W] = 24'hAAAAAA;
    waitDone(40);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkLog("snapshot", 9);
    checkOutput("snapshot_row3_literal", dut_log[3].data, 64'h0000_0000_0010_0033);

    // Second start during row 4 is ignored
    $display("[TB] scenario: start while busy");
    clearLog();
    setRows(24'h00ABC0, 24'h000001);
    pulseStart();
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(40);
    repeat (12) applyStimulus(1'b0, 1'b0, 1'b0);
    checkLog("restart", 9);

    // Reset while row 5 is stalled, then a fresh run with row 7 all ones
    $display("[TB] scenario: reset mid-run");
    clearLog();
    setRows(24'h000200, 24'h000002);
    pulseStart();
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("abort_write", 64'(avm.write), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_row", 64'(dbg_row), 64'd0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("abort_done_count", 64'(done_count), 64'd0);
    checkOutput("abort_write_count", 64'(dut_log.size()), 64'd5);

    clearLog();
    setRows(24'h000300, 24'h000003);
    rows_ref[7]                 = 24'hFFFFFF;
    c_in[7*RES_W +: RES_W]      = 24'hFFFFFF;
    pulseStart();
    waitDone(40);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkLog("rerun", 9);
    if (dut_log.size() == N_ROWS) begin
      checkOutput("row7_writedata", dut_log[7].data, 64'h0000_0000_00FF_FFFF);
      checkOutput("row7_byteenable", 64'(dut_log[7].be), 64'hFF);
      checkOutput("row0_address", 64'(dut_log[0].addr), 64'd16);
    end else begin
      checkOutput("rerun_log_size", 64'(dut_log.size()), 64'(N_ROWS));
    end

    // Simultaneous reset and start: reset wins
    $display("[TB] scenario: reset with start");
    clearLog();
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("rststart_busy", 64'(busy), 64'd0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rststart_write_count", 64'(dut_log.size()), 64'd0);
    checkOutput("rststart_done_count", 64'(done_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
